// File: rtl/mdu_sequencer_if.sv
// Bus between the EXE stage (master) and the multiply/divide sequencer (slave).
//
// Handshake: op_valid is a level request from EXE. The sequencer takes the op
// only in an IDLE cycle with flush low, and it raises stall in that same cycle.
// It keeps stall high until the result cycle, so op_valid stays high until the
// result is written. hilo_we is a one-cycle valid for hi_out/lo_out. It has no
// ready because HILO always takes the write. flush overrides everything: stall
// and hilo_we drop at once and the sequencer is back in IDLE on the next edge.
// dbgState mirrors the sequencer FSM state for checkers and waveforms.
interface mdu_sequencer_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] hilo_hi;
  logic [31:0] hilo_lo;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [2:0]  dbgState;

  modport master (
    output op_valid, op_code, src_a, src_b, flush, hilo_hi, hilo_lo,
    input  stall, busy, hilo_we, hi_out, lo_out, dbgState
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, flush, hilo_hi, hilo_lo,
    output stall, busy, hilo_we, hi_out, lo_out, dbgState
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the HI/LO unit.
// MULT/MULTU take 3 stall cycles: the accept cycle plus two MUL cycles.
// DIV/DIVU take 34 stall cycles: the accept cycle, a 32-step restoring divide
// on operand magnitudes, and one DIVFIX cycle that applies the signs.
// Divide by zero goes straight to DONE with HI=src_a and LO=all ones.
// Optional feature macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which
// accumulate into {hilo_hi,hilo_lo}. When the macro is undefined, op codes with
// bit 2 set are not accepted.
module mdu_sequencer (
  input  logic           clk,
  input  logic           rst,
  mdu_sequencer_if.slave mdu
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL    = 3'd1,
    DIV    = 3'd2,
    DIVFIX = 3'd3,
    DONE   = 3'd4
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [4:0]  iterCnt;

  logic        opUnsigned;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] quoReg;
  logic [31:0] remReg;
  logic [63:0] prodReg;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  logic        stall;
  logic        hiloWe;
  logic        accept;
  logic        opAllowed;
  logic        isDivOp;
  logic        divByZero;
  logic [31:0] srcAMag;

`ifdef MDU_MADD_EN
  logic        accMode;
  logic        subMode;
  logic [63:0] accBase;

  assign opAllowed = 1'b1;
`else
  assign opAllowed = ~mdu.op_code[2];
`endif

  // Op code 010/011 is DIV/DIVU. Every other accepted code is a multiply.
  assign isDivOp   = ~mdu.op_code[2] & mdu.op_code[1];
  assign divByZero = (mdu.src_b == 32'd0);
  assign accept    = (state == IDLE) && mdu.op_valid && !mdu.flush && opAllowed;
  assign srcAMag   = (~mdu.op_code[0] & mdu.src_a[31]) ? (32'd0 - mdu.src_a) : mdu.src_a;

  // After sign or zero extension to 64 bits, the low 64 bits of one unsigned
  // multiply are correct for both MULT and MULTU.
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;
  logic [63:0] mulResult;

  assign mulA    = opUnsigned ? {32'd0, opA} : {{32{opA[31]}}, opA};
  assign mulB    = opUnsigned ? {32'd0, opB} : {{32{opB[31]}}, opB};
  assign product = mulA * mulB;

`ifdef MDU_MADD_EN
  assign mulResult = !accMode ? prodReg :
                     (subMode ? (accBase - prodReg) : (accBase + prodReg));
`else
  assign mulResult = prodReg;
`endif

  // Restoring divider datapath. The remainder stays below the divisor, so a
  // 33-bit trial subtraction is enough and bit 32 of the trial is the borrow.
  logic        divSigned;
  logic [31:0] divisor;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        quoNeg;
  logic        remNeg;
  logic [31:0] quoFinal;
  logic [31:0] remFinal;

  assign divSigned = ~opUnsigned;
  assign divisor   = (divSigned & opB[31]) ? (32'd0 - opB) : opB;
  assign shifted   = {remReg, quoReg[31]};
  assign trial     = shifted - {1'b0, divisor};
  assign quoNeg    = divSigned & (opA[31] ^ opB[31]);
  assign remNeg    = divSigned & opA[31];
  assign quoFinal  = quoNeg ? (32'd0 - quoReg) : quoReg;
  assign remFinal  = remNeg ? (32'd0 - remReg) : remReg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and handshake outputs. A flush overrides everything else.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    hiloWe    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (isDivOp) nextState = divByZero ? DONE : DIV;
          else         nextState = MUL;
        end
      end
      MUL: begin
        stall = 1'b1;
        if (iterCnt == 5'd1) nextState = DONE;
      end
      DIV: begin
        stall = 1'b1;
        if (iterCnt == 5'd31) nextState = DIVFIX;
      end
      DIVFIX: begin
        stall     = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        hiloWe    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (mdu.flush) begin
      nextState = IDLE;
      stall     = 1'b0;
      hiloWe    = 1'b0;
    end
  end

  // Iteration counter: counts cycles in MUL/DIV and clears on leaving them.
  // It is set back to 0 explicitly at the end and never wraps.
  always_ff @(posedge clk) begin
    if (rst || mdu.flush)
      iterCnt <= 5'd0;
    else if ((state == MUL || state == DIV) && nextState == state)
      iterCnt <= iterCnt + 5'd1;
    else
      iterCnt <= 5'd0;
  end

  // Operand latches, multiply and divide datapath, and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA        <= 32'd0;
      opB        <= 32'd0;
      opUnsigned <= 1'b0;
      quoReg     <= 32'd0;
      remReg     <= 32'd0;
      prodReg    <= 64'd0;
      hiOut      <= 32'd0;
      loOut      <= 32'd0;
`ifdef MDU_MADD_EN
      accMode    <= 1'b0;
      subMode    <= 1'b0;
      accBase    <= 64'd0;
`endif
    end else begin
      if (accept) begin
        opA        <= mdu.src_a;
        opB        <= mdu.src_b;
        opUnsigned <= mdu.op_code[0];
        quoReg     <= srcAMag;
        remReg     <= 32'd0;
`ifdef MDU_MADD_EN
        accMode    <= mdu.op_code[2];
        subMode    <= mdu.op_code[1];
        accBase    <= {mdu.hilo_hi, mdu.hilo_lo};
`endif
        if (isDivOp && divByZero) begin
          hiOut <= mdu.src_a;
          loOut <= 32'hFFFF_FFFF;
        end
      end
      case (state)
        MUL: begin
          if (iterCnt == 5'd0) prodReg <= product;
          if (nextState == DONE) {hiOut, loOut} <= mulResult;
        end
        DIV: begin
          if (!trial[32]) begin
            remReg <= trial[31:0];
            quoReg <= {quoReg[30:0], 1'b1};
          end else begin
            remReg <= shifted[31:0];
            quoReg <= {quoReg[30:0], 1'b0};
          end
        end
        DIVFIX: begin
          if (nextState == DONE) begin
            hiOut <= remFinal;
            loOut <= quoFinal;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.stall    = stall;
  assign mdu.busy     = (state != IDLE);
  assign mdu.hilo_we  = hiloWe;
  assign mdu.hi_out   = hiOut;
  assign mdu.lo_out   = loOut;
  assign mdu.dbgState = state;

endmodule
